// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with two-flop synchroniser, per-bit edge capture, irq mask and level irq.
// Optional per-bit debounce filter is enabled with `define PIO_IN_DEBOUNCE_EN.
module pio_in_edge_irq #(
    parameter int                  WIDTH           = 8,
    parameter int                  EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0]    RESET_MASK      = {WIDTH{1'b0}},
    parameter int                  DEBOUNCE_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             address,
    input  logic                   chipselect,
    input  logic                   read,
    input  logic                   write,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] data_in_s;
    logic [1:0]       settle_q;
    logic [1:0]       settle_d;
    logic             settle_done_s;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic [31:0]      rd_mux_s;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_s;
    logic             rd_s;
    logic             unused_wdata;

    // Two-flop synchroniser and previous-value register for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= {WIDTH{1'b0}};
            s2_q   <= {WIDTH{1'b0}};
            prev_q <= {WIDTH{1'b0}};
        end else begin
            s1_q   <= in_port;
            s2_q   <= s1_q;
            prev_q <= data_in_s;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt_q [WIDTH];
    logic [WIDTH-1:0] db_data_q;

    // A bit only follows s2 after it has disagreed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            db_data_q <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] != db_data_q[i]) begin
                    if (db_cnt_q[i] == CNT_LAST) begin
                        db_data_q[i] <= s2_q[i];
                        db_cnt_q[i]  <= {CNT_W{1'b0}};
                    end else begin
                        db_cnt_q[i]  <= db_cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= {CNT_W{1'b0}};
                end
            end
        end
    end

    assign data_in_s = db_data_q;
`else
    assign data_in_s = s2_q;
`endif

    assign wr_s          = chipselect & write;
    assign rd_s          = chipselect & read;
    assign settle_done_s = (settle_q == 2'd3);
    assign rise_s        = data_in_s & ~prev_q;
    assign fall_s        = ~data_in_s & prev_q;
    assign unused_wdata  = ^writedata;

    // Edge polarity selection
    always_comb begin
        edge_s = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            0:       edge_s = rise_s;
            1:       edge_s = fall_s;
            2:       edge_s = rise_s | fall_s;
            default: edge_s = rise_s | fall_s;
        endcase
    end

    // Next-state for settle counter, mask and edge capture; a new edge beats a same-cycle clear
    always_comb begin
        settle_d = settle_q;
        mask_d   = mask_q;
        clr_s    = {WIDTH{1'b0}};
        if (settle_done_s) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 2'd1;
        end
        if (wr_s && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (wr_s && (address == ADDR_EDGE)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        if (settle_done_s) begin
            cap_d = (cap_q & ~clr_s) | edge_s;
        end else begin
            cap_d = cap_q & ~clr_s;
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_DATA: rd_mux_s[WIDTH-1:0] = data_in_s;
            ADDR_RSVD: rd_mux_s            = 32'd0;
            ADDR_MASK: rd_mux_s[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_mux_s[WIDTH-1:0] = cap_q;
            default:   rd_mux_s            = 32'd0;
        endcase
        if (rd_s) begin
            readdata_d = rd_mux_s;
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Control/status registers and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_q   <= 2'd0;
            mask_q     <= RESET_MASK;
            cap_q      <= {WIDTH{1'b0}};
            readdata_q <= 32'd0;
        end else begin
            settle_q   <= settle_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: one rising-edge and one any-edge instance on shared stimulus.
module tb_pio_in_edge_irq;

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata_r;
    logic [31:0] readdata_a;
    logic        irq_r;
    logic        irq_a;
    int          vectors;
    int          miscompares;

    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .RESET_MASK(8'h00), .DEBOUNCE_CYCLES(4)) dut_r (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata_r),
        .in_port(in_port), .irq(irq_r)
    );

    pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(8'h00), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port), .irq(irq_a)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] rr, output logic [31:0] ra);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        rr = readdata_r; ra = readdata_a;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rr, ra, exp_cap;
        in_port = 8'hFF; reset = 1'b1;
        tick(3);
        vectors++;
        if (readdata_r !== 32'd0 || readdata_a !== 32'd0 || irq_r !== 1'b0 || irq_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: rd_r=%h rd_a=%h irq=%b%b required 0", readdata_r, readdata_a, irq_r, irq_a);
        end
        reset = 1'b0;
        tick(10);
        bus_read(2'd0, rr, ra);
        vectors++;
        if (rr !== 32'h000000FF || ra !== 32'h000000FF) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h required 000000ff", rr, ra);
        end
`ifdef PIO_IN_DEBOUNCE_EN
        exp_cap = 32'h000000FF;
`else
        exp_cap = 32'h00000000;
`endif
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== exp_cap || ra !== exp_cap) begin
            miscompares++;
            $display("FAIL reset_capture: got %h/%h required %h", rr, ra, exp_cap);
        end
        bus_read(2'd2, rr, ra);
        vectors++;
        if (rr !== 32'd0 || ra !== 32'd0 || irq_r !== 1'b0 || irq_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mask: mask %h/%h irq %b%b required 0", rr, ra, irq_r, irq_a);
        end
    endtask

    task automatic test_rise_irq;
        logic [31:0] rr, ra;
        in_port = 8'h00;
        tick(12);
        bus_write(2'd3, 32'h000000FF);
        bus_write(2'd2, 32'h00000001);
        vectors++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_no_pending: irq %b%b required 0", irq_r, irq_a);
        end
        in_port = 8'h01;
        tick(LAT - 1);
        vectors++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_early: irq %b%b required 0", irq_r, irq_a);
        end
        tick(1);
        vectors++;
        if (irq_r !== 1'b1 || irq_a !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_rise: irq %b%b required 1", irq_r, irq_a);
        end
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'h00000001 || ra !== 32'h00000001) begin
            miscompares++;
            $display("FAIL capture_rise: got %h/%h required 00000001", rr, ra);
        end
        bus_write(2'd3, 32'h00000001);
        vectors++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: irq %b%b required 0", irq_r, irq_a);
        end
        bus_read(2'd0, rr, ra);
        vectors++;
        if (rr !== 32'h00000001 || ra !== 32'h00000001) begin
            miscompares++;
            $display("FAIL data_in_01: got %h/%h required 00000001", rr, ra);
        end
    endtask

    task automatic test_any_edge;
        logic [31:0] rr, ra;
        in_port = 8'h09;
        tick(LAT + 1);
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'h00000008 || ra !== 32'h00000008) begin
            miscompares++;
            $display("FAIL bit3_rise: got %h/%h required 00000008", rr, ra);
        end
        bus_write(2'd3, 32'h00000008);
        in_port = 8'h01;
        tick(LAT + 1);
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'h00000000 || ra !== 32'h00000008) begin
            miscompares++;
            $display("FAIL bit3_fall: got %h/%h required 00000000/00000008", rr, ra);
        end
        bus_write(2'd3, 32'h000000FF);
    endtask

    task automatic test_clear_collision;
        logic [31:0] rr, ra;
        in_port = 8'h05;
        tick(LAT - 1);
        bus_write(2'd3, 32'h00000004);
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'h00000004 || ra !== 32'h00000004) begin
            miscompares++;
            $display("FAIL set_wins: got %h/%h required 00000004", rr, ra);
        end
        bus_write(2'd3, 32'h00000004);
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'h00000000 || ra !== 32'h00000000) begin
            miscompares++;
            $display("FAIL w1c: got %h/%h required 00000000", rr, ra);
        end
    endtask

    task automatic test_mask;
        logic [31:0] rr, ra;
        bus_write(2'd2, 32'h00000000);
        in_port = 8'h15;
        tick(LAT + 1);
        vectors++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            miscompares++;
            $display("FAIL masked_irq: irq %b%b required 0", irq_r, irq_a);
        end
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'h00000010 || ra !== 32'h00000010) begin
            miscompares++;
            $display("FAIL capture_bit4: got %h/%h required 00000010", rr, ra);
        end
        bus_write(2'd2, 32'hFFFFFF10);
        vectors++;
        if (irq_r !== 1'b1 || irq_a !== 1'b1) begin
            miscompares++;
            $display("FAIL unmask_irq: irq %b%b required 1", irq_r, irq_a);
        end
        bus_read(2'd2, rr, ra);
        vectors++;
        if (rr !== 32'h00000010 || ra !== 32'h00000010) begin
            miscompares++;
            $display("FAIL mask_readback: got %h/%h required 00000010", rr, ra);
        end
        bus_write(2'd0, 32'hFFFFFFFF);
        bus_write(2'd1, 32'hFFFFFFFF);
        bus_read(2'd1, rr, ra);
        vectors++;
        if (rr !== 32'd0 || ra !== 32'd0) begin
            miscompares++;
            $display("FAIL reserved: got %h/%h required 00000000", rr, ra);
        end
        bus_read(2'd0, rr, ra);
        vectors++;
        if (rr !== 32'h00000015 || ra !== 32'h00000015) begin
            miscompares++;
            $display("FAIL data_ro: got %h/%h required 00000015", rr, ra);
        end
        tick(2);
        vectors++;
        if (readdata_r !== 32'h00000015 || readdata_a !== 32'h00000015) begin
            miscompares++;
            $display("FAIL readdata_hold: got %h/%h required 00000015", readdata_r, readdata_a);
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] rr, ra, exp_cap;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        vectors++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_irq: irq %b%b required 0", irq_r, irq_a);
        end
        tick(10);
`ifdef PIO_IN_DEBOUNCE_EN
        exp_cap = 32'h00000015;
`else
        exp_cap = 32'h00000000;
`endif
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== exp_cap || ra !== exp_cap) begin
            miscompares++;
            $display("FAIL midop_capture: got %h/%h required %h", rr, ra, exp_cap);
        end
        bus_read(2'd2, rr, ra);
        vectors++;
        if (rr !== 32'd0 || ra !== 32'd0) begin
            miscompares++;
            $display("FAIL midop_mask: got %h/%h required 00000000", rr, ra);
        end
    endtask

`ifdef PIO_IN_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] rr, ra;
        in_port = 8'h14;
        tick(12);
        bus_write(2'd3, 32'h000000FF);
        in_port = 8'h15;
        tick(2);
        in_port = 8'h14;
        tick(12);
        bus_read(2'd0, rr, ra);
        vectors++;
        if (rr !== 32'h00000014 || ra !== 32'h00000014) begin
            miscompares++;
            $display("FAIL glitch_data: got %h/%h required 00000014", rr, ra);
        end
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'd0 || ra !== 32'd0) begin
            miscompares++;
            $display("FAIL glitch_capture: got %h/%h required 00000000", rr, ra);
        end
        in_port = 8'h15;
        tick(6);
        in_port = 8'h14;
        bus_read(2'd0, rr, ra);
        vectors++;
        if (rr !== 32'h00000015 || ra !== 32'h00000015) begin
            miscompares++;
            $display("FAIL pulse_data: got %h/%h required 00000015", rr, ra);
        end
        tick(12);
        bus_read(2'd3, rr, ra);
        vectors++;
        if (rr !== 32'h00000001 || ra !== 32'h00000001) begin
            miscompares++;
            $display("FAIL pulse_capture: got %h/%h required 00000001", rr, ra);
        end
    endtask
`endif

    initial begin
        clk = 1'b0; reset = 1'b1; address = 2'd0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; writedata = 32'd0; in_port = 8'h00;
        vectors = 0; miscompares = 0;
        @(negedge clk);
        test_reset();
        test_rise_irq();
        test_any_edge();
        test_clear_collision();
        test_mask();
        test_reset_midop();
`ifdef PIO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
